// File: rtl/traffic_lamp_sequencer.sv
// rtl/traffic_lamp_sequencer.sv - lamp driver with min green, fixed yellow and all-red clearance
// Lamp outputs are decoded from next-state so they change on the same edge as the state register.
module traffic_lamp_sequencer #(
  parameter int MIN_GRN_CYCLES = 8,
  parameter int YEL_CYCLES     = 4,
  parameter int ALLRED_CYCLES  = 2,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ns_req,
  input  logic ew_req,
  output logic ns_red,
  output logic ns_yel,
  output logic ns_grn,
  output logic ew_red,
  output logic ew_yel,
  output logic ew_grn,
  output logic in_transition
);

  typedef enum logic [2:0] {
    ALL_RED,
    NS_GRN,
    NS_YEL,
    EW_GRN,
    EW_YEL
  } state_t;

  localparam logic [CNT_W-1:0] GRN_LOAD    = CNT_W'(MIN_GRN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YEL_LOAD    = CNT_W'(YEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       lamps_q, lamps_d;
  logic             in_transition_q, in_transition_d;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
    case (state_q)
      ALL_RED: begin
        // Conflicting or absent requests keep the junction all-red.
        if (cnt_zero) begin
          if (ns_req && !ew_req) begin
            state_d = NS_GRN;
            cnt_d   = GRN_LOAD;
          end else if (ew_req && !ns_req) begin
            state_d = EW_GRN;
            cnt_d   = GRN_LOAD;
          end
        end
      end
      NS_GRN: begin
        if (cnt_zero && !ns_req) begin
          state_d = NS_YEL;
          cnt_d   = YEL_LOAD;
        end
      end
      EW_GRN: begin
        if (cnt_zero && !ew_req) begin
          state_d = EW_YEL;
          cnt_d   = YEL_LOAD;
        end
      end
      NS_YEL, EW_YEL: begin
        if (cnt_zero) begin
          state_d = ALL_RED;
          cnt_d   = ALLRED_LOAD;
        end
      end
      default: begin
        state_d = ALL_RED;
        cnt_d   = ALLRED_LOAD;
      end
    endcase
  end

  // Lamp order: {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn}
  always_comb begin
    lamps_d = 6'b100_100;
    case (state_d)
      NS_GRN:  lamps_d = 6'b001_100;
      NS_YEL:  lamps_d = 6'b010_100;
      EW_GRN:  lamps_d = 6'b100_001;
      EW_YEL:  lamps_d = 6'b100_010;
      default: lamps_d = 6'b100_100;
    endcase
    in_transition_d = !(state_d == NS_GRN || state_d == EW_GRN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ALL_RED;
      cnt_q           <= ALLRED_LOAD;
      lamps_q         <= 6'b100_100;
      in_transition_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      lamps_q         <= lamps_d;
      in_transition_q <= in_transition_d;
    end
  end

  assign {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn} = lamps_q;
  assign in_transition = in_transition_q;

endmodule
